fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 The block SHALL have port imem_addr  output  32  word-aligned read address.
REQ-006 The block SHALL have port imem_ack  input  1  memory reports imem_rdata valid this cycle.
REQ-007 The block SHALL have port imem_rdata  input  32  instruction word.
REQ-008 The block SHALL have port instr  output  32  registered instruction presented to decode.
REQ-009 The block SHALL have port instr_pc  output  32  address of instr.
REQ-010 The block SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-011 The block SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-012 The block SHALL have port jump  input  1  accepted instruction is a J-type jump.
REQ-013 The block SHALL have port branch  input  1  accepted instruction is a BEQ-class branch.
REQ-014 The block SHALL have port zero  input  1  ALU zero result for the accepted instruction.
REQ-015 The block SHALL have port retired  output  32  count of accepted instructions.

Function
REQ-016 State machine SHALL have states IDLE, FETCH, HOLD.
REQ-017 IDLE SHALL last exactly one cycle after rst_n deasserts, with imem_req=0, then move to FETCH.
REQ-018 In FETCH: imem_req=1 and imem_addr=pc; both stable until imem_ack.
REQ-019 On imem_ack in FETCH: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1 next cycle, state->HOLD; the request is not re-issued.
REQ-020 Minimum latency SHALL be 1 cycle from ack to instr_valid; imem_req SHALL be 0 in the ack-following cycle.
REQ-021 imem_ack outside FETCH SHALL be ignored, with no state or output change.
REQ-022 In HOLD: instr, instr_pc, instr_valid SHALL be held constant while instr_ready=0.
REQ-023 Handshake = instr_valid & instr_ready; jump, branch and zero SHALL be sampled only in the handshake cycle.
REQ-024 On handshake: pc<=next_pc, retired<=retired+1, instr_valid<=0, state->FETCH.
REQ-025 seq = instr_pc+4, computed mod 2^32 (wrap 32'hFFFF_FFFC -> 0).
REQ-026 next_pc priority: jump -> {seq[31:28], instr[25:0], 2'b00}; else branch&zero -> seq + (sign-extended instr[15:0] << 2), mod 2^32; else seq.
REQ-027 Simultaneous jump and branch SHALL select jump.
REQ-028 branch=1 with zero=0 SHALL select seq.
REQ-029 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 imem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-031 rst_n=0 SHALL immediately and asynchronously force: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, retired=0.
REQ-032 Reset mid-fetch or mid-hold SHALL abandon the pending transfer; the first request after release SHALL be to RESET_PC.

Verification
REQ-033 Reset release, memory acks every request 1 cycle later, instr_ready=1, no jump/branch -> imem_addr sequence 0,4,8,C; retired=4 after the 4th handshake.
REQ-034 Hold instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc and instr_valid unchanged, imem_req=0, retired unchanged.
REQ-035 Instruction at instr_pc 0x100 with imm16=16'hFFFE, branch=1, zero=1 -> next imem_addr 0x0FC; same with zero=0 -> 0x104.
REQ-036 Instruction at instr_pc 0x3000_0010 with instr[25:0]=26'h0000040, jump=1 and branch=1 -> next imem_addr 0x3000_0100.
REQ-037 rst_n pulsed low while imem_req=1 at address 0x20 -> imem_req drops in the same cycle; after release, one IDLE cycle, then request at RESET_PC; a stray ack during IDLE is ignored.
REQ-038 instr_pc 0xFFFF_FFFC, no branch -> next imem_addr 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher.
// Issues one read to instruction memory, registers the returned word for
// decode, holds it until decode accepts it, then computes the next PC from
// the jump/branch/zero flags sampled in the accepting cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] retired
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned J_IDX_W = 26;
  localparam logic [XLEN-1:0] RESET_ADDR = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            req_next;
  logic [XLEN-1:0] addr_next;
  logic [XLEN-1:0] instr_next;
  logic [XLEN-1:0] instr_pc_next;
  logic            valid_next;
  logic [XLEN-1:0] retired_next;

  logic            handshake_c;
  logic [XLEN-1:0] seq_c;
  logic [XLEN-1:0] branch_off_c;
  logic [XLEN-1:0] jump_target_c;
  logic [XLEN-1:0] branch_target_c;
  logic [XLEN-1:0] next_pc_c;

  // Next-PC candidates derived from the instruction currently held for decode
  always_comb begin
    seq_c           = instr_pc + XLEN'(4);
    branch_off_c    = {{(XLEN - IMM_W - 2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
    branch_target_c = seq_c + branch_off_c;
    jump_target_c   = {seq_c[XLEN-1:XLEN-4], instr[J_IDX_W-1:0], 2'b00};
    if (jump) begin
      next_pc_c = jump_target_c;
    end else if (branch && zero) begin
      next_pc_c = branch_target_c;
    end else begin
      next_pc_c = seq_c;
    end
  end

  // Next-state and next-output logic; everything holds unless a transition fires
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_next      = imem_req;
    addr_next     = imem_addr;
    instr_next    = instr;
    instr_pc_next = instr_pc;
    valid_next    = instr_valid;
    retired_next  = retired;
    handshake_c   = 1'b0;

    unique case (state)
      IDLE: begin
        state_next = FETCH;
        req_next   = 1'b1;
        addr_next  = {pc[XLEN-1:2], 2'b00};
      end
      FETCH: begin
        if (imem_ack) begin
          state_next    = HOLD;
          req_next      = 1'b0;
          instr_next    = imem_rdata;
          instr_pc_next = pc;
          valid_next    = 1'b1;
        end
      end
      HOLD: begin
        handshake_c = instr_valid && instr_ready;
        if (handshake_c) begin
          state_next   = FETCH;
          pc_next      = next_pc_c;
          retired_next = retired + XLEN'(1);
          valid_next   = 1'b0;
          req_next     = 1'b1;
          addr_next    = {next_pc_c[XLEN-1:2], 2'b00};
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State register and registered outputs with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_ADDR;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      retired     <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      imem_req    <= req_next;
      imem_addr   <= addr_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= valid_next;
      retired     <= retired_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed sequences, a chained next-PC vector table, and a
// randomized run against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] retired;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] word;
    logic        j;
    logic        b;
    logic        z;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[13];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump(jump), .branch(branch), .zero(zero),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next fetch address from the architectural rules, using plain arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                           input logic j, input logic b, input logic z);
    logic [31:0] seq;
    logic signed [15:0] imm;
    int off;
    seq = pc + 32'd4;
    imm = w[15:0];
    off = imm;
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_total++;
      $display("FAIL req_timeout: imem_req 0 after 20 cycles, required 1");
    end
  endtask

  // Wait for a request, ack it at once, and check the word lands one cycle later
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word, input string tag);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    chk({tag, "_addr"}, imem_addr, exp_addr);
    imem_ack = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_req_off"}, 32'(imem_req), 32'd0);
    chk({tag, "_instr"}, instr, word);
    chk({tag, "_ipc"}, instr_pc, exp_addr);
  endtask

  task automatic handshake(input logic j, input logic b, input logic z);
    instr_ready = 1'b1;
    jump = j;
    branch = b;
    zero = z;
    step();
    instr_ready = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_exp;
    logic [31:0] hold_instr;
    logic [31:0] mpc;
    logic [31:0] mword;
    logic [31:0] mret;
    bit holding;
    bit ok;

    // Table: each entry is fetched at the previous entry's expected target
    vecs[0]  = '{32'h0000_FFFE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC};
    vecs[1]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[2]  = '{32'h0800_0040, 1'b1, 1'b0, 1'b0, 32'h0000_0100};
    vecs[3]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_00FC};
    vecs[4]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0100};
    vecs[5]  = '{32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0104};
    vecs[6]  = '{32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h0FFF_FFFC};
    vecs[7]  = '{32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h1FFF_FFFC};
    vecs[8]  = '{32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 32'h2FFF_FFFC};
    vecs[9]  = '{32'h0800_0004, 1'b1, 1'b0, 1'b0, 32'h3000_0010};
    vecs[10] = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'h3000_0100};
    vecs[11] = '{32'h1000_0010, 1'b0, 1'b1, 1'b1, 32'h3000_0144};
    vecs[12] = '{32'h1000_FFFF, 1'b0, 1'b0, 1'b1, 32'h3000_0148};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_retired", retired, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Sequential fetch stream with immediate acks and a ready decoder
    for (int k = 0; k < 4; k++) begin
      fetch_one(32'(k * 4), 32'h0000_0013 + 32'(k), "seq");
      handshake(1'b0, 1'b0, 1'b0);
    end
    chk("seq_retired", retired, 32'd4);
    chk("seq_next_addr", imem_addr, 32'h10);

    // Decode stalls for 5 cycles; stray acks and flags must have no effect
    fetch_one(32'h10, 32'hCAFE_0001, "hold");
    hold_instr = instr;
    for (int k = 0; k < 5; k++) begin
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      jump = 1'b1;
      branch = 1'b1;
      zero = 1'b1;
      step();
      chk("hold_instr", instr, hold_instr);
      chk("hold_ipc", instr_pc, 32'h10);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_retired", retired, 32'd4);
    end
    imem_ack = 1'b0;
    handshake(1'b0, 1'b0, 1'b0);
    chk("hold_next_addr", imem_addr, 32'h14);
    chk("hold_retired_after", retired, 32'd5);

    // Reset while a request to 0x20 is pending
    for (int k = 5; k < 8; k++) begin
      fetch_one(32'(k * 4), 32'h0, "pre");
      handshake(1'b0, 1'b0, 1'b0);
    end
    wait_req(ok);
    chk("mid_addr", imem_addr, 32'h20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_retired", retired, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_idle_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    step();
    imem_ack = 1'b0;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_valid", 32'(instr_valid), 32'd0);
    chk("rel_instr", instr, 32'h0);
    step();
    chk("rel_req_stable", 32'(imem_req), 32'd1);
    chk("rel_addr_stable", imem_addr, 32'h0);

    // Next-PC vector table
    pc_exp = 32'h0;
    for (int i = 0; i < 13; i++) begin
      fetch_one(pc_exp, vecs[i].word, $sformatf("vec%0d", i));
      handshake(vecs[i].j, vecs[i].b, vecs[i].z);
      chk($sformatf("vec%0d_next", i), imem_addr, vecs[i].next);
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'd1);
      chk($sformatf("vec%0d_align", i), 32'(imem_addr[1:0]), 32'd0);
      pc_exp = vecs[i].next;
    end
    chk("vec_retired", retired, 32'd13);

    // Randomized run against the reference model
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    step();
    holding = 1'b0;
    mpc = 32'h0;
    mret = 32'h0;
    mword = 32'h0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rnd_valid", 32'(instr_valid), 32'(holding));
      chk("rnd_req", 32'(imem_req), 32'(!holding));
      chk("rnd_retired", retired, mret);
      if (holding) begin
        chk("rnd_instr", instr, mword);
        chk("rnd_ipc", instr_pc, mpc);
      end else begin
        chk("rnd_addr", imem_addr, mpc);
      end
      jump = ($urandom_range(0, 3) == 0);
      branch = ($urandom_range(0, 1) == 1);
      zero = ($urandom_range(0, 1) == 1);
      instr_ready = ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom();
      if (holding) begin
        imem_ack = ($urandom_range(0, 3) == 0);
        if (instr_ready) begin
          mpc = ref_next(mpc, mword, jump, branch, zero);
          mret = mret + 32'd1;
          holding = 1'b0;
        end
      end else begin
        imem_ack = ($urandom_range(0, 2) == 0);
        if (imem_ack) begin
          mword = imem_rdata;
          holding = 1'b1;
        end
      end
      step();
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    zero = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
